// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one 8x8 multiplier between NUM_REQ requesters.
// Define MULT_ARB_WDOG_EN to add a WAIT-state watchdog with err/err_flag reporting.
module mult_share_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int WDOG_CYC = 63
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [15:0]            res,
  output logic                   mult_ld,
  output logic [7:0]             mult_a,
  output logic [7:0]             mult_b,
  input  logic                   mult_rdy,
  input  logic [15:0]            mult_res,
  output logic                   err,
  output logic                   err_flag
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  if (NUM_REQ < 2 || NUM_REQ > 4 || WDOG_CYC < 1 || WDOG_CYC > 255) begin : g_param_check
    $error("mult_share_arbiter: NUM_REQ must be 2..4 and WDOG_CYC 1..255");
  end

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    DONE
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win_q;
  logic [IW-1:0]   win_idx;
  logic            win_vld;
  logic            rdy_q;
  logic            rdy_rise;
  int              idx;

  // Scan from the highest offset down so the nearest requester at or after ptr is kept last.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        win_idx = IW'(idx);
        win_vld = 1'b1;
      end
    end
  end

  // Only a fresh rising edge completes an op; a ready level left from the last op is ignored.
  assign rdy_rise = mult_rdy & ~rdy_q;

`ifdef MULT_ARB_WDOG_EN
  localparam logic [7:0] WDOG_LIM = 8'(WDOG_CYC - 1);
  logic [7:0] wdog_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      win_q    <= '0;
      gnt      <= '0;
      done     <= '0;
      res      <= 16'h0000;
      mult_ld  <= 1'b0;
      mult_a   <= 8'h00;
      mult_b   <= 8'h00;
      rdy_q    <= 1'b0;
`ifdef MULT_ARB_WDOG_EN
      err      <= 1'b0;
      err_flag <= 1'b0;
      wdog_cnt <= 8'h00;
`endif
    end else begin
      rdy_q   <= mult_rdy;
      done    <= '0;
      mult_ld <= 1'b0;
`ifdef MULT_ARB_WDOG_EN
      err     <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (win_vld) begin
            win_q   <= win_idx;
            mult_a  <= req_a[8*int'(win_idx) +: 8];
            mult_b  <= req_b[8*int'(win_idx) +: 8];
            gnt     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
            mult_ld <= 1'b1;
            state   <= LOAD;
          end
        end
        LOAD: begin
`ifdef MULT_ARB_WDOG_EN
          wdog_cnt <= 8'h00;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (rdy_rise) begin
            res   <= mult_res;
            done  <= gnt;
            state <= DONE;
          end
`ifdef MULT_ARB_WDOG_EN
          else if (wdog_cnt == WDOG_LIM) begin
            res      <= 16'h0000;
            done     <= gnt;
            err      <= 1'b1;
            err_flag <= 1'b1;
            state    <= DONE;
          end else begin
            wdog_cnt <= wdog_cnt + 8'h01;
          end
`endif
        end
        DONE: begin
          gnt   <= '0;
          ptr   <= (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MULT_ARB_WDOG_EN
  assign err      = 1'b0;
  assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: reset, single op, contention, stale ready,
// operand boundaries, reset during WAIT and the optional watchdog.
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [15:0] res;
  logic        mult_ld;
  logic [7:0]  mult_a;
  logic [7:0]  mult_b;
  logic        mult_rdy;
  logic [15:0] mult_res;
  logic        err;
  logic        err_flag;

  int n_checks = 0;
  int n_fail   = 0;

  mult_share_arbiter #(.NUM_REQ(2), .WDOG_CYC(63)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .done(done), .res(res), .mult_ld(mult_ld),
    .mult_a(mult_a), .mult_b(mult_b), .mult_rdy(mult_rdy), .mult_res(mult_res),
    .err(err), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  // Combinational stand-in for the multiplier datapath; ready is driven by the tests.
  assign mult_res = 16'(mult_a) * 16'(mult_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ld(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mult_ld === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Runs one op: find LOAD, raise ready lat cycles later, sample at the DONE cycle.
  task automatic serve(input int lat, input logic keep_rdy, output logic ok,
                       output logic [1:0] g, output logic [1:0] d,
                       output logic [15:0] r, output int ld_cnt);
    wait_ld(ok);
    g = gnt;
    d = 2'b00;
    r = 16'h0;
    ld_cnt = 0;
    if (!ok) return;
    ld_cnt = 1;
    for (int i = 0; i < lat; i++) begin
      tick();
      if (mult_ld === 1'b1) ld_cnt++;
    end
    mult_rdy = 1'b1;
    tick();
    d = done;
    r = res;
    if (!keep_rdy) mult_rdy = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 2'b00; req_a = 16'h0; req_b = 16'h0; mult_rdy = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_gnt: got %b expected 00", gnt); end
    n_checks++; if (done !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 00", done); end
    n_checks++; if (res !== 16'h0) begin n_fail++; $display("[TB] FAIL reset_res: got %h expected 0000", res); end
    n_checks++; if (mult_ld !== 1'b0 || mult_a !== 8'h0 || mult_b !== 8'h0) begin
      n_fail++; $display("[TB] FAIL reset_mult: got ld=%b a=%h b=%h expected 0/00/00", mult_ld, mult_a, mult_b); end
    n_checks++; if (err !== 1'b0 || err_flag !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_err: got err=%b flag=%b expected 0/0", err, err_flag); end
  endtask

  task automatic test_contention();
    logic ok; logic [1:0] g, d; logic [15:0] r; int lc;
    logic [1:0]  exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [15:0] exp_r [4] = '{16'd15, 16'd63, 16'd15, 16'd63};
    req = 2'b11; req_a = {8'd7, 8'd3}; req_b = {8'd9, 8'd5};
    for (int i = 0; i < 4; i++) begin
      serve(2, 1'b0, ok, g, d, r, lc);
      if (i == 3) req = 2'b00;
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL cont_ld%0d: got no load expected load", i); end
      n_checks++; if (g !== exp_g[i]) begin n_fail++; $display("[TB] FAIL cont_gnt%0d: got %b expected %b", i, g, exp_g[i]); end
      n_checks++; if (d !== exp_g[i]) begin n_fail++; $display("[TB] FAIL cont_done%0d: got %b expected %b", i, d, exp_g[i]); end
      n_checks++; if (r !== exp_r[i]) begin n_fail++; $display("[TB] FAIL cont_res%0d: got %0d expected %0d", i, r, exp_r[i]); end
    end
    tick();
    n_checks++; if (gnt !== 2'b00) begin n_fail++; $display("[TB] FAIL cont_release: got %b expected 00", gnt); end
  endtask

  task automatic test_single_op();
    logic ok; logic [1:0] g, d; logic [15:0] r; int lc;
    req = 2'b01; req_a = {8'd0, 8'd200}; req_b = {8'd0, 8'd150};
    serve(4, 1'b0, ok, g, d, r, lc);
    n_checks++; if (ok !== 1'b1 || g !== 2'b01) begin n_fail++; $display("[TB] FAIL single_gnt: got ok=%b gnt=%b expected 1/01", ok, g); end
    n_checks++; if (lc != 1) begin n_fail++; $display("[TB] FAIL single_ld_count: got %0d expected 1", lc); end
    n_checks++; if (d !== 2'b01) begin n_fail++; $display("[TB] FAIL single_done: got %b expected 01", d); end
    n_checks++; if (r !== 16'd30000) begin n_fail++; $display("[TB] FAIL single_res: got %0d expected 30000", r); end
    n_checks++; if (mult_a !== 8'd200 || mult_b !== 8'd150) begin
      n_fail++; $display("[TB] FAIL single_operands: got %0d,%0d expected 200,150", mult_a, mult_b); end
    req = 2'b00;
    tick();
    n_checks++; if (done !== 2'b00 || gnt !== 2'b00) begin
      n_fail++; $display("[TB] FAIL single_after: got done=%b gnt=%b expected 00/00", done, gnt); end
    n_checks++; if (res !== 16'd30000) begin n_fail++; $display("[TB] FAIL single_res_hold: got %0d expected 30000", res); end
  endtask

  task automatic test_stale_ready();
    logic ok; logic [1:0] g, d; logic [15:0] r; int lc; logic early;
    req = 2'b10; req_a = {8'd11, 8'h00}; req_b = {8'd13, 8'h00};
    serve(1, 1'b1, ok, g, d, r, lc);
    req = 2'b00;
    n_checks++; if (d !== 2'b10 || r !== 16'd143) begin
      n_fail++; $display("[TB] FAIL stale_first: got done=%b res=%0d expected 10/143", d, r); end
    tick();
    req = 2'b01; req_a = {8'd0, 8'h12}; req_b = {8'd0, 8'h10};
    wait_ld(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL stale_ld: got no load expected load"); end
    early = |done;
    for (int i = 0; i < 3; i++) begin tick(); early |= |done; end
    mult_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin tick(); early |= |done; end
    mult_rdy = 1'b1;
    tick();
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("[TB] FAIL stale_early_done: got 1 expected 0"); end
    n_checks++; if (done !== 2'b01) begin n_fail++; $display("[TB] FAIL stale_done: got %b expected 01", done); end
    n_checks++; if (res !== 16'd288) begin n_fail++; $display("[TB] FAIL stale_res: got %0d expected 288", res); end
    req = 2'b00; mult_rdy = 1'b0;
    tick();
  endtask

  task automatic test_boundary();
    logic ok; logic [1:0] g, d; logic [15:0] r; int lc;
    req = 2'b10; req_a = {8'hFF, 8'h00}; req_b = {8'hFF, 8'h5A};
    serve(3, 1'b0, ok, g, d, r, lc);
    req = 2'b01;
    n_checks++; if (g !== 2'b10 || d !== 2'b10) begin n_fail++; $display("[TB] FAIL bound_ff_gnt: got gnt=%b done=%b expected 10/10", g, d); end
    n_checks++; if (r !== 16'hFE01) begin n_fail++; $display("[TB] FAIL bound_ff_res: got %h expected fe01", r); end
    serve(2, 1'b0, ok, g, d, r, lc);
    req = 2'b00;
    n_checks++; if (g !== 2'b01 || d !== 2'b01) begin n_fail++; $display("[TB] FAIL bound_zero_gnt: got gnt=%b done=%b expected 01/01", g, d); end
    n_checks++; if (r !== 16'h0000) begin n_fail++; $display("[TB] FAIL bound_zero_res: got %h expected 0000", r); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    logic ok; logic [1:0] g, d; logic [15:0] r; int lc;
    req = 2'b10; req_a = {8'd9, 8'd4}; req_b = {8'd9, 8'd6};
    wait_ld(ok);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; req = 2'b00;
    n_checks++; if (gnt !== 2'b00 || done !== 2'b00 || mult_ld !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midwait_ctrl: got gnt=%b done=%b ld=%b expected 00/00/0", gnt, done, mult_ld); end
    n_checks++; if (res !== 16'h0 || mult_a !== 8'h0 || mult_b !== 8'h0) begin
      n_fail++; $display("[TB] FAIL midwait_data: got res=%h a=%h b=%h expected 0/0/0", res, mult_a, mult_b); end
    req = 2'b11;
    serve(2, 1'b0, ok, g, d, r, lc);
    req = 2'b10;
    n_checks++; if (g !== 2'b01 || r !== 16'd24) begin
      n_fail++; $display("[TB] FAIL midwait_ptr: got gnt=%b res=%0d expected 01/24", g, r); end
    serve(2, 1'b0, ok, g, d, r, lc);
    req = 2'b00;
    n_checks++; if (g !== 2'b10 || d !== 2'b10 || r !== 16'd81) begin
      n_fail++; $display("[TB] FAIL midwait_req1: got gnt=%b done=%b res=%0d expected 10/10/81", g, d, r); end
    tick();
  endtask

  task automatic test_watchdog();
    logic ok;
    req = 2'b01; req_a = {8'd0, 8'd2}; req_b = {8'd0, 8'd3}; mult_rdy = 1'b0;
    wait_ld(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL wdog_ld: got no load expected load"); end
`ifdef MULT_ARB_WDOG_EN
    begin
      int cnt = 0;
      for (int i = 1; i <= 100; i++) begin
        tick();
        if (done !== 2'b00) begin cnt = i; break; end
      end
      req = 2'b00;
      n_checks++; if (cnt != 64) begin n_fail++; $display("[TB] FAIL wdog_latency: got %0d expected 64", cnt); end
      n_checks++; if (done !== 2'b01 || err !== 1'b1) begin
        n_fail++; $display("[TB] FAIL wdog_strobe: got done=%b err=%b expected 01/1", done, err); end
      n_checks++; if (res !== 16'h0 || err_flag !== 1'b1) begin
        n_fail++; $display("[TB] FAIL wdog_res_flag: got res=%h flag=%b expected 0/1", res, err_flag); end
      tick(); tick(); tick();
      n_checks++; if (err !== 1'b0 || err_flag !== 1'b1) begin
        n_fail++; $display("[TB] FAIL wdog_sticky: got err=%b flag=%b expected 0/1", err, err_flag); end
    end
`else
    begin
      logic seen_done = 1'b0;
      logic seen_err  = 1'b0;
      for (int i = 0; i < 80; i++) begin
        tick();
        seen_done |= |done;
        seen_err  |= err | err_flag;
      end
      req = 2'b00;
      n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("[TB] FAIL nowdog_done: got 1 expected 0"); end
      n_checks++; if (seen_err !== 1'b0) begin n_fail++; $display("[TB] FAIL nowdog_err: got 1 expected 0"); end
      n_checks++; if (gnt !== 2'b01) begin n_fail++; $display("[TB] FAIL nowdog_gnt: got %b expected 01", gnt); end
    end
`endif
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if (err_flag !== 1'b0 || gnt !== 2'b00) begin
      n_fail++; $display("[TB] FAIL wdog_reset: got flag=%b gnt=%b expected 0/00", err_flag, gnt); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_op();
    test_stale_ready();
    test_boundary();
    test_reset_mid_wait();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no end of test expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
